// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, funct3 codes and LSU types.
// Used by load_store_unit and lsu_lane_align via import riscv_pkg::*.
package riscv_pkg;

   localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LD  = 3'd3;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_LWU = 3'd6;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;
   localparam logic [2:0] F3_SD  = 3'd3;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_RSP
   } lsu_state_e;

   typedef enum logic [1:0] {
      EXC_LD_MISALIGN   = 2'd0,
      EXC_ST_MISALIGN   = 2'd1,
      EXC_BUS_TIMEOUT   = 2'd2,
      EXC_ILLEGAL_WIDTH = 2'd3
   } lsu_exc_cause_e;

   // Access size in bytes; funct3[1:0] encodes log2(size).
   function automatic logic [3:0] f3_bytes(input logic [2:0] f3);
      return 4'd1 << f3[1:0];
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte enables/replicated data, and
// load lane extraction with sign/zero extension. Params: XLEN (32|64).
module lsu_lane_align
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]                  i_st_funct3,
   input  logic [$clog2(XLEN/8)-1:0]   i_st_off,
   input  logic [XLEN-1:0]             i_st_data,
   output logic [XLEN/8-1:0]           o_be,
   output logic [XLEN-1:0]             o_wdata,
   input  logic [2:0]                  i_ld_funct3,
   input  logic [$clog2(XLEN/8)-1:0]   i_ld_off,
   input  logic [XLEN-1:0]             i_ld_rdata,
   output logic [XLEN-1:0]             o_ld_data
);

   localparam int NB = XLEN / 8;

   logic [NB-1:0]   w_be_base;
   logic [XLEN-1:0] w_shift;

   always_comb begin
      w_be_base = '0;
      o_wdata   = '0;
      case (i_st_funct3[1:0])
         2'd0: begin
            w_be_base = NB'(1);
            o_wdata   = {(XLEN/8){i_st_data[7:0]}};
         end
         2'd1: begin
            w_be_base = NB'(3);
            o_wdata   = {(XLEN/16){i_st_data[15:0]}};
         end
         2'd2: begin
            w_be_base = NB'(15);
            o_wdata   = {(XLEN/32){i_st_data[31:0]}};
         end
         default: begin
            w_be_base = '1;
            o_wdata   = i_st_data;
         end
      endcase
      o_be = w_be_base << i_st_off;
   end

   assign w_shift = i_ld_rdata >> {i_ld_off, 3'b000};

   // funct3[2] selects zero extension.
   always_comb begin
      o_ld_data = w_shift;
      case (i_ld_funct3[1:0])
         2'd0: o_ld_data = i_ld_funct3[2] ? XLEN'(w_shift[7:0])
                                          : XLEN'($signed(w_shift[7:0]));
         2'd1: o_ld_data = i_ld_funct3[2] ? XLEN'(w_shift[15:0])
                                          : XLEN'($signed(w_shift[15:0]));
         2'd2: o_ld_data = i_ld_funct3[2] ? XLEN'(w_shift[31:0])
                                          : XLEN'($signed(w_shift[31:0]));
         default: o_ld_data = w_shift;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage LSU: B/H/W(/D) loads and stores over a valid/ready bus with
// response timeout and fault reporting. Ports: ex_* in, mem_* bus, wb_*/exc_*
// out. Optional LSU_MISALIGN_TRAP_EN: trap misaligned instead of aligning down.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [6:0]        ex_opcode,
   input  logic [2:0]        ex_funct3,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [XLEN-1:0]   ex_store_data,
   input  logic [4:0]        ex_rd,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_we,
   output logic [XLEN/8-1:0] mem_req_be,
   output logic [XLEN-1:0]   mem_req_wdata,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_rdata,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic              exc_valid,
   output logic [1:0]        exc_cause,
   output logic [ADDR_W-1:0] exc_addr,
   output logic              busy
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // The fault pulse is registered, so the last bus cycle is one earlier
   // than the cycle the exception becomes visible.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   lsu_state_e      r_state;
   lsu_exc_cause_e  r_exc_cause;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_is_ld;
   logic [2:0]        r_funct3;
   logic [OFF_W-1:0]  r_off;
   logic [4:0]        r_rd;
   logic [ADDR_W-1:0] r_ex_addr;
   logic              r_req_valid;
   logic [ADDR_W-1:0] r_req_addr;
   logic              r_req_we;
   logic [NB-1:0]     r_req_be;
   logic [XLEN-1:0]   r_req_wdata;
   logic              r_wb_valid;
   logic              r_wb_we;
   logic [4:0]        r_wb_rd;
   logic [XLEN-1:0]   r_wb_data;
   logic              r_exc_valid;
   logic [ADDR_W-1:0] r_exc_addr;

   logic              w_is_ld;
   logic              w_is_st;
   logic              w_illegal;
   logic              w_trap_mis;
   logic              w_hit;
   logic [OFF_W-1:0]  w_off;
   logic [OFF_W-1:0]  w_off_eff;
   logic [OFF_W-1:0]  w_size_mask;
   logic [NB-1:0]     w_be;
   logic [XLEN-1:0]   w_wdata;
   logic [XLEN-1:0]   w_ld_data;

   assign w_is_ld     = ex_opcode == OPCODE_LOAD;
   assign w_is_st     = ex_opcode == OPCODE_STORE;
   assign w_off       = ex_addr[OFF_W-1:0];
   assign w_size_mask = OFF_W'(f3_bytes(ex_funct3) - 4'd1);
   assign w_hit       = r_cnt == CNT_LAST;

   assign w_illegal = w_is_st ?
      (ex_funct3 > ((XLEN == 32) ? F3_SW : F3_SD)) :
      (w_is_ld && ((ex_funct3 == 3'd7) ||
       ((XLEN == 32) && (ex_funct3 == F3_LD || ex_funct3 == F3_LWU))));

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_off_eff  = w_off;
   assign w_trap_mis = |(w_off & w_size_mask);
`else
   assign w_off_eff  = w_off & ~w_size_mask;
   assign w_trap_mis = 1'b0;
`endif

   lsu_lane_align #(.XLEN(XLEN)) u_align (
      .i_st_funct3 (ex_funct3),
      .i_st_off    (w_off_eff),
      .i_st_data   (ex_store_data),
      .o_be        (w_be),
      .o_wdata     (w_wdata),
      .i_ld_funct3 (r_funct3),
      .i_ld_off    (r_off),
      .i_ld_rdata  (mem_rsp_rdata),
      .o_ld_data   (w_ld_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= LSU_IDLE;
         r_cnt       <= '0;
         r_is_ld     <= 1'b0;
         r_funct3    <= '0;
         r_off       <= '0;
         r_rd        <= '0;
         r_ex_addr   <= '0;
         r_req_valid <= 1'b0;
         r_req_addr  <= '0;
         r_req_we    <= 1'b0;
         r_req_be    <= '0;
         r_req_wdata <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_we     <= 1'b0;
         r_wb_rd     <= '0;
         r_wb_data   <= '0;
         r_exc_valid <= 1'b0;
         r_exc_cause <= EXC_LD_MISALIGN;
         r_exc_addr  <= '0;
      end else begin
         r_wb_valid  <= 1'b0;
         r_exc_valid <= 1'b0;
         unique case (r_state)
            LSU_IDLE: begin
               if (ex_valid && (w_is_ld || w_is_st)) begin
                  r_cnt     <= '0;
                  r_is_ld   <= w_is_ld;
                  r_funct3  <= ex_funct3;
                  r_off     <= w_off_eff;
                  r_rd      <= ex_rd;
                  r_ex_addr <= ex_addr;
                  if (w_illegal || w_trap_mis) begin
                     r_exc_valid <= 1'b1;
                     r_exc_addr  <= ex_addr;
                     r_exc_cause <= w_illegal ? EXC_ILLEGAL_WIDTH :
                                    w_is_ld   ? EXC_LD_MISALIGN :
                                                EXC_ST_MISALIGN;
                  end else begin
                     r_state     <= LSU_REQ;
                     r_req_valid <= 1'b1;
                     r_req_addr  <= {ex_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     r_req_we    <= w_is_st;
                     r_req_be    <= w_be;
                     r_req_wdata <= w_is_st ? w_wdata : '0;
                  end
               end
            end
            LSU_REQ: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_hit) begin
                  r_state     <= LSU_IDLE;
                  r_req_valid <= 1'b0;
                  r_exc_valid <= 1'b1;
                  r_exc_cause <= EXC_BUS_TIMEOUT;
                  r_exc_addr  <= r_ex_addr;
               end else if (mem_req_ready) begin
                  r_state     <= LSU_RSP;
                  r_req_valid <= 1'b0;
               end
            end
            LSU_RSP: begin
               r_cnt <= r_cnt + 1'b1;
               // A response in the final cycle still wins over the timeout.
               if (mem_rsp_valid) begin
                  r_state    <= LSU_IDLE;
                  r_wb_valid <= 1'b1;
                  r_wb_we    <= r_is_ld;
                  r_wb_rd    <= r_rd;
                  r_wb_data  <= r_is_ld ? w_ld_data : '0;
               end else if (w_hit) begin
                  r_state     <= LSU_IDLE;
                  r_exc_valid <= 1'b1;
                  r_exc_cause <= EXC_BUS_TIMEOUT;
                  r_exc_addr  <= r_ex_addr;
               end
            end
            default: r_state <= LSU_IDLE;
         endcase
      end
   end

   assign ex_ready      = r_state == LSU_IDLE;
   assign busy          = r_state != LSU_IDLE;
   assign mem_req_valid = r_req_valid;
   assign mem_req_addr  = r_req_addr;
   assign mem_req_we    = r_req_we;
   assign mem_req_be    = r_req_be;
   assign mem_req_wdata = r_req_wdata;
   assign wb_valid      = r_wb_valid;
   assign wb_we         = r_wb_we;
   assign wb_rd         = r_wb_rd;
   assign wb_data       = r_wb_data;
   assign exc_valid     = r_exc_valid;
   assign exc_cause     = r_exc_cause;
   assign exc_addr      = r_exc_addr;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (XLEN=32, TIMEOUT_CYCLES=16):
// directed vector table, random ops vs. a reference model, corner sequences.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [3:0]  mem_req_be;
   logic [31:0] mem_req_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        exc_valid;
   logic [1:0]  exc_cause;
   logic [31:0] exc_addr;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   load_store_unit #(
      .XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        exc;
      bit [1:0]  cause;
      bit [31:0] req_addr;
      bit [3:0]  be;
      bit [31:0] wdata;
      bit [31:0] wb;
   } exp_t;

   typedef struct {
      bit        st;
      bit [2:0]  f3;
      bit [31:0] addr;
      bit [31:0] data;
      bit [31:0] rdata;
      exp_t      e;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   // Reference: access rules computed byte by byte with plain arithmetic.
   function automatic exp_t model(input bit st, input bit [2:0] f3,
                                  input bit [31:0] addr, input bit [31:0] data,
                                  input bit [31:0] rdata);
      exp_t   e;
      int     size;
      int     off;
      longint v;
      longint span;
      e = '{default: '0};
      if (st ? (f3 > 2) : (f3 == 3 || f3 >= 6)) begin
         e.exc   = 1'b1;
         e.cause = 2'd3;
         return e;
      end
      size = 1 << f3[1:0];
      off  = int'(addr % 4);
      if (off % size != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
         e.exc   = 1'b1;
         e.cause = st ? 2'd1 : 2'd0;
         return e;
`else
         off = off - off % size;
`endif
      end
      e.req_addr = addr - addr % 4;
      e.be       = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++)
         e.wdata[8*i +: 8] = 8'(data >> (8 * (i % size)));
      span = longint'(1) << (8 * size);
      v    = (longint'(rdata) >> (8 * off)) % span;
      if (!f3[2] && v >= span / 2) v = v - span;
      e.wb = 32'(v);
      return e;
   endfunction

   // Starts in the cycle the op is presented; ends in the wb cycle
   // (or the fault cycle) so another op can start immediately.
   task automatic run_op(input bit st, input bit [2:0] f3,
                         input bit [31:0] addr, input bit [31:0] data,
                         input bit [31:0] rdata, input bit [4:0] rd,
                         input int rdy_wait, input int rsp_wait,
                         input exp_t e);
      ex_valid      = 1'b1;
      ex_opcode     = st ? 7'h23 : 7'h03;
      ex_funct3     = f3;
      ex_addr       = addr;
      ex_store_data = data;
      ex_rd         = rd;
      chk("ex_ready_accept", ex_ready, 1);
      tick();
      ex_valid = 1'b0;
      if (e.exc) begin
         chk("exc_valid", exc_valid, 1);
         chk("exc_cause", exc_cause, e.cause);
         chk("exc_addr", exc_addr, addr);
         chk("exc_no_req", mem_req_valid, 0);
         chk("exc_ex_ready", ex_ready, 1);
         return;
      end
      for (int c = 0; c <= rdy_wait; c++) begin
         chk("req_valid", mem_req_valid, 1);
         chk("req_addr", mem_req_addr, e.req_addr);
         chk("req_we", mem_req_we, st);
         if (st) begin
            chk("req_be", mem_req_be, e.be);
            chk("req_wdata", mem_req_wdata, e.wdata);
         end
         mem_req_ready = (c == rdy_wait);
         // Stray responses during REQ must be ignored.
         mem_rsp_valid = (c != rdy_wait);
         mem_rsp_rdata = ~rdata;
         tick();
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      for (int c = 0; c <= rsp_wait; c++) begin
         chk("rsp_no_wb", wb_valid, 0);
         chk("rsp_no_req", mem_req_valid, 0);
         mem_rsp_valid = (c == rsp_wait);
         mem_rsp_rdata = rdata;
         tick();
      end
      mem_rsp_valid = 1'b0;
      chk("wb_valid", wb_valid, 1);
      chk("wb_we", wb_we, !st);
      chk("wb_rd", wb_rd, rd);
      if (!st) chk("wb_data", wb_data, e.wb);
      chk("wb_no_exc", exc_valid, 0);
      chk("wb_ex_ready", ex_ready, 1);
      chk("wb_busy", busy, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      exp_t e;
      bit st;
      bit [2:0] f3;
      bit [31:0] a, d, r;

      rst_n = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_funct3 = '0;
      ex_addr = '0; ex_store_data = '0; ex_rd = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
      tick(); tick();
      chk("rst_ex_ready", ex_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_exc_valid", exc_valid, 0);
      rst_n = 1'b1;
      tick();

      // st f3 addr data rdata {exc cause req_addr be wdata wb}
      vecs.push_back('{1, 0, 32'h1003, 32'hA5, 0,
                       '{0, 0, 32'h1000, 4'h8, 32'hA5A5A5A5, 0}});
      vecs.push_back('{0, 1, 32'h2002, 0, 32'h80011234,
                       '{0, 0, 32'h2000, 0, 0, 32'hFFFF8001}});
      vecs.push_back('{0, 5, 32'h2002, 0, 32'h80011234,
                       '{0, 0, 32'h2000, 0, 0, 32'h00008001}});
`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back('{0, 2, 32'h3001, 0, 32'hDEADBEEF,
                       '{1, 0, 0, 0, 0, 0}});
      vecs.push_back('{1, 1, 32'h7001, 32'h1234, 0,
                       '{1, 1, 0, 0, 0, 0}});
`else
      vecs.push_back('{0, 2, 32'h3001, 0, 32'hDEADBEEF,
                       '{0, 0, 32'h3000, 0, 0, 32'hDEADBEEF}});
      vecs.push_back('{1, 1, 32'h7001, 32'h1234, 0,
                       '{0, 0, 32'h7000, 4'h3, 32'h12341234, 0}});
`endif
      vecs.push_back('{0, 0, 32'h4001, 0, 32'h00008000,
                       '{0, 0, 32'h4000, 0, 0, 32'hFFFFFF80}});
      vecs.push_back('{0, 4, 32'h4003, 0, 32'hFF000000,
                       '{0, 0, 32'h4000, 0, 0, 32'h000000FF}});
      vecs.push_back('{1, 2, 32'h5000, 32'h12345678, 0,
                       '{0, 0, 32'h5000, 4'hF, 32'h12345678, 0}});
      vecs.push_back('{1, 1, 32'h5002, 32'hABCDBEEF, 0,
                       '{0, 0, 32'h5000, 4'hC, 32'hBEEFBEEF, 0}});
      vecs.push_back('{0, 3, 32'h6000, 0, 0, '{1, 3, 0, 0, 0, 0}});
      vecs.push_back('{0, 6, 32'h6004, 0, 0, '{1, 3, 0, 0, 0, 0}});
      vecs.push_back('{0, 7, 32'h6008, 0, 0, '{1, 3, 0, 0, 0, 0}});
      vecs.push_back('{1, 3, 32'h600C, 0, 0, '{1, 3, 0, 0, 0, 0}});

      foreach (vecs[i])
         run_op(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].data,
                vecs[i].rdata, 5'(i + 1), 0, 0, vecs[i].e);
      tick();
      chk("exc_one_pulse", exc_valid, 0);

      // Non-memory opcode: accepted and dropped.
      ex_valid = 1'b1; ex_opcode = 7'h33; ex_funct3 = 3'd2;
      ex_addr = 32'h9000;
      tick();
      ex_valid = 1'b0;
      chk("drop_exc", exc_valid, 0);
      chk("drop_req", mem_req_valid, 0);
      chk("drop_busy", busy, 0);
      tick();
      chk("drop_wb", wb_valid, 0);

      // Timeout with ready held low: fault 16 cycles after accept.
      ex_valid = 1'b1; ex_opcode = 7'h03; ex_funct3 = 3'd2;
      ex_addr = 32'h0100; ex_rd = 5'd9;
      tick();
      ex_valid = 1'b0;
      k = 1;
      while (k < 40 && !exc_valid) begin
         tick();
         k++;
      end
      chk("to_cycle", k, 16);
      chk("to_cause", exc_cause, 2);
      chk("to_addr", exc_addr, 32'h0100);
      chk("to_no_wb", wb_valid, 0);
      chk("to_req_drop", mem_req_valid, 0);
      tick();
      chk("to_ex_ready", ex_ready, 1);
      chk("to_pulse", exc_valid, 0);

      // Ready low 3 cycles, response in the final allowed cycle.
      e = model(0, 3'd2, 32'h8000, 0, 32'hCAFEF00D);
      run_op(0, 3'd2, 32'h8000, 0, 32'hCAFEF00D, 5'd7, 3, 10, e);
      tick();
      chk("late_no_exc", exc_valid, 0);

      // Reset while waiting for the response.
      ex_valid = 1'b1; ex_opcode = 7'h03; ex_funct3 = 3'd2;
      ex_addr = 32'hA000; ex_rd = 5'd3;
      tick();
      ex_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("rsp_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rstrsp_busy", busy, 0);
      chk("rstrsp_wb", wb_valid, 0);
      chk("rstrsp_req", mem_req_valid, 0);
      chk("rstrsp_ready", ex_ready, 1);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h11111111;
      tick();
      mem_rsp_valid = 1'b0;
      chk("late_rsp_wb", wb_valid, 0);
      tick();
      chk("late_rsp_wb2", wb_valid, 0);

      // Random operations against the reference model.
      for (int n = 0; n < 60; n++) begin
         st = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         d  = $urandom;
         r  = $urandom;
         e  = model(st, f3, a, d, r);
         run_op(st, f3, a, d, r, 5'($urandom_range(0, 31)),
                $urandom_range(0, 4), $urandom_range(0, 4), e);
      end
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
